// File: rtl/z80_bus_pkg.sv
// Shared z80 bus types and constants used by the core-facing memory responder.
package z80_bus_pkg;

    typedef enum logic [2:0] {
        CYC_NONE,
        CYC_MEM_RD,
        CYC_MEM_WR,
        CYC_IO_RD,
        CYC_IO_WR,
        CYC_INTA
    } cycle_t;

    typedef enum logic [1:0] {
        IDLE,
        WAITING,
        ACTIVE,
        HOLD
    } resp_state_t;

    typedef struct packed {
        cycle_t      cyc;
        logic [15:0] addr;
    } bus_req_t;

    localparam logic [7:0] BUS_FLOAT     = 8'hzz;
    localparam logic [7:0] OPEN_BUS_DATA = 8'hFF;
    localparam int         WAIT_W        = 3;

    function automatic logic is_write(input cycle_t c);
        return (c == CYC_MEM_WR) || (c == CYC_IO_WR);
    endfunction

endpackage

// File: rtl/z80_wait_gen.sv
// Loadable wait-state down-counter; WAIT_L is low while the count is nonzero.
module z80_wait_gen
    import z80_bus_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [WAIT_W-1:0] count,
    output logic              wait_l,
    output logic              done
);

    logic [WAIT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (load)
            cnt <= count;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign wait_l = (cnt == '0);
    // Last wait cycle: the owner moves to its data phase on the coming edge.
    assign done   = (cnt == WAIT_W'(1));

endmodule

// File: rtl/z80_mem_responder.sv
// Bus-side responder for the z80 core: RAM with write-protected ROM window,
// four I/O registers, interrupt-acknowledge vector and programmable wait states.
module z80_mem_responder
    import z80_bus_pkg::*;
#(
    parameter int         MEM_DEPTH  = 4096,
    parameter int         ROM_SIZE   = 1024,
    parameter int         MEM_WAIT   = 0,
    parameter int         IO_WAIT    = 1,
    parameter logic [7:0] IO_BASE    = 8'h10,
    parameter logic [7:0] INT_VECTOR = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr_bus,
    inout  wire  [7:0]  data_bus,
    input  logic        M1_L,
    input  logic        MREQ_L,
    input  logic        IORQ_L,
    input  logic        RD_L,
    input  logic        WR_L,
    input  logic        RFSH_L,
    output logic        WAIT_L,
    input  logic        ld_en,
    input  logic [15:0] ld_addr,
    input  logic [7:0]  ld_data,
    output logic        protocol_err
);

    localparam int                AW         = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [16:0]       MEM_LIMIT  = 17'(MEM_DEPTH);
    localparam logic [16:0]       ROM_LIMIT  = 17'(ROM_SIZE);
    localparam logic [WAIT_W-1:0] MEM_WAIT_C = WAIT_W'(MEM_WAIT);
    localparam logic [WAIT_W-1:0] IO_WAIT_C  = WAIT_W'(IO_WAIT);

    logic [7:0]        mem [MEM_DEPTH];
    logic [3:0][7:0]   io_regs;

    resp_state_t       state, state_nxt;
    bus_req_t          req, cur;
    cycle_t            cyc_in;
    logic              bad_combo, start, ld_wait, clr_wait, wait_done;
    logic              strobe_off, load_rd, rd_drv, rd_drv_q;
    logic [WAIT_W-1:0] wcnt_in;
    logic [7:0]        rd_val, rd_data, io_off;
    logic              io_hit, cur_in_mem, mem_we, io_we;

    // Illegal strobe pairs are flagged and never classified as a cycle.
    assign bad_combo = (!MREQ_L && !IORQ_L) || (!RD_L && !WR_L);

    always_comb begin
        cyc_in = CYC_NONE;
        if (!bad_combo) begin
            if (!IORQ_L && !M1_L)                 cyc_in = CYC_INTA;
            else if (!IORQ_L && !RD_L)            cyc_in = CYC_IO_RD;
            else if (!IORQ_L && !WR_L)            cyc_in = CYC_IO_WR;
            else if (!MREQ_L && RFSH_L && !RD_L)  cyc_in = CYC_MEM_RD;
            else if (!MREQ_L && RFSH_L && !WR_L)  cyc_in = CYC_MEM_WR;
        end
    end

    always_comb begin
        case (cyc_in)
            CYC_MEM_RD, CYC_MEM_WR: wcnt_in = MEM_WAIT_C;
            CYC_IO_RD, CYC_IO_WR:   wcnt_in = IO_WAIT_C;
            default:                wcnt_in = '0;
        endcase
    end

    // In IDLE the live bus is decoded so a zero-wait read can load data at once.
    always_comb begin
        cur = req;
        if (state == IDLE) begin
            cur.cyc  = cyc_in;
            cur.addr = addr_bus;
        end
    end

    assign io_off     = cur.addr[7:0] - IO_BASE;
    assign io_hit     = (io_off[7:2] == 6'd0);
    assign cur_in_mem = ({1'b0, cur.addr} < MEM_LIMIT);

    always_comb begin
        rd_val = OPEN_BUS_DATA;
        rd_drv = 1'b0;
        case (cur.cyc)
            CYC_MEM_RD: begin
                rd_drv = 1'b1;
                if (cur_in_mem) rd_val = mem[cur.addr[AW-1:0]];
            end
            CYC_IO_RD: begin
                if (io_hit) begin
                    rd_drv = 1'b1;
                    rd_val = io_regs[io_off[1:0]];
                end
            end
            CYC_INTA: begin
                rd_drv = 1'b1;
                rd_val = INT_VECTOR;
            end
            default: ;
        endcase
    end

    assign strobe_off = (req.cyc == CYC_INTA) ? IORQ_L :
                        (is_write(req.cyc) ? WR_L : RD_L);

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        ld_wait   = 1'b0;
        clr_wait  = 1'b0;
        case (state)
            IDLE: begin
                if (cyc_in != CYC_NONE) begin
                    start = 1'b1;
                    if (wcnt_in != '0) begin
                        ld_wait   = 1'b1;
                        state_nxt = WAITING;
                    end else begin
                        state_nxt = ACTIVE;
                    end
                end
            end
            WAITING: begin
                if (strobe_off) begin
                    clr_wait  = 1'b1;
                    state_nxt = IDLE;
                end else if (wait_done) begin
                    state_nxt = ACTIVE;
                end
            end
            ACTIVE:  state_nxt = HOLD;
            HOLD:    if (strobe_off) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign load_rd = (state_nxt == ACTIVE) && (state != ACTIVE);
    assign mem_we  = (state == ACTIVE) && (req.cyc == CYC_MEM_WR) &&
                     ({1'b0, req.addr} >= ROM_LIMIT) && cur_in_mem;
    assign io_we   = (state == ACTIVE) && (req.cyc == CYC_IO_WR) && io_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            req          <= '0;
            rd_data      <= '0;
            rd_drv_q     <= 1'b0;
            protocol_err <= 1'b0;
            io_regs      <= '0;
        end else begin
            state <= state_nxt;
            if (start)
                req <= cur;
            if (load_rd) begin
                rd_data  <= rd_val;
                rd_drv_q <= rd_drv;
            end
            if (state == IDLE && bad_combo)
                protocol_err <= 1'b1;
            if (io_we)
                io_regs[io_off[1:0]] <= data_bus;
        end
    end

    // Backing store is not reset; a bus write beats a same-address backdoor load.
    always_ff @(posedge clk) begin
        if (ld_en && ({1'b0, ld_addr} < MEM_LIMIT))
            mem[ld_addr[AW-1:0]] <= ld_data;
        if (mem_we)
            mem[req.addr[AW-1:0]] <= data_bus;
    end

    assign data_bus = ((state == ACTIVE || state == HOLD) && rd_drv_q) ? rd_data : BUS_FLOAT;

    z80_wait_gen u_wait (
        .clk    (clk),
        .rst    (rst),
        .load   (ld_wait),
        .clear  (clr_wait),
        .count  (wcnt_in),
        .wait_l (WAIT_L),
        .done   (wait_done)
    );

endmodule

// File: tb/tb_z80_mem_responder.sv
// Scoreboard bench for z80_mem_responder: randomized bus cycles checked against a map-level model.
module tb_z80_mem_responder;

    localparam int         MEM_DEPTH  = 4096;
    localparam int         ROM_SIZE   = 1024;
    localparam int         MEM_WAIT   = 2;
    localparam int         IO_WAIT    = 1;
    localparam logic [7:0] IO_BASE    = 8'h10;
    localparam logic [7:0] INT_VECTOR = 8'hFF;

    localparam int K_MRD = 0, K_M1 = 1, K_MWR = 2, K_IORD = 3,
                   K_IOWR = 4, K_INTA = 5, K_RFSH = 6, K_BAD = 7;

    typedef struct {
        int          kind;
        logic [15:0] addr;
        int          waits;
        bit          wr;
        logic [7:0]  data;
        bit          err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] addr_bus = '0;
    logic        M1_L = 1'b1, MREQ_L = 1'b1, IORQ_L = 1'b1;
    logic        RD_L = 1'b1, WR_L = 1'b1, RFSH_L = 1'b1;
    logic        WAIT_L, protocol_err;
    logic        ld_en = 1'b0;
    logic [15:0] ld_addr = '0;
    logic [7:0]  ld_data = '0;
    logic        tb_oe = 1'b0;
    logic [7:0]  tb_data = '0;
    tri0  [7:0]  data_bus;

    // Undriven bus reads as 8'h00 through the pull-down.
    assign data_bus = tb_oe ? tb_data : 8'hzz;

    z80_mem_responder #(
        .MEM_DEPTH (MEM_DEPTH), .ROM_SIZE (ROM_SIZE), .MEM_WAIT (MEM_WAIT),
        .IO_WAIT (IO_WAIT), .IO_BASE (IO_BASE), .INT_VECTOR (INT_VECTOR)
    ) dut (
        .clk (clk), .rst (rst), .addr_bus (addr_bus), .data_bus (data_bus),
        .M1_L (M1_L), .MREQ_L (MREQ_L), .IORQ_L (IORQ_L), .RD_L (RD_L),
        .WR_L (WR_L), .RFSH_L (RFSH_L), .WAIT_L (WAIT_L), .ld_en (ld_en),
        .ld_addr (ld_addr), .ld_data (ld_data), .protocol_err (protocol_err)
    );

    always #5 clk = ~clk;

    // Reference model: plain arrays indexed by address / port.
    logic [7:0] ram [MEM_DEPTH];
    logic [7:0] io  [4];
    bit         err_m = 1'b0;

    int   n_checks = 0, n_fail = 0;
    exp_t sb[$];
    bit   cyc_active = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit port_hit(input logic [15:0] a);
        int p = int'(a[7:0]);
        return p >= int'(IO_BASE) && p < int'(IO_BASE) + 4;
    endfunction

    // Monitor: collects one sample per negedge while a cycle is on the bus.
    logic [7:0] smp[$];
    int         wlow = 0, zchk = 0;
    bit         was_active = 1'b0;
    always @(negedge clk) begin
        exp_t  e;
        string tag;
        bit    early;
        if (cyc_active) begin
            smp.push_back(data_bus);
            if (!WAIT_L) wlow++;
            was_active = 1'b1;
        end else if (was_active) begin
            was_active = 1'b0;
            if (sb.size() == 0) begin
                check("scoreboard_empty", 8'd0, 8'd1);
            end else begin
                e   = sb.pop_front();
                tag = $sformatf("k%0d_a%h", e.kind, e.addr);
                check({tag, "_waits"}, 8'(wlow), 8'(e.waits));
                if (!e.wr) begin
                    if (smp.size() < e.waits + 2) begin
                        check({tag, "_short"}, 8'(smp.size()), 8'(e.waits + 2));
                    end else begin
                        early = 1'b0;
                        for (int i = 0; i <= e.waits; i++)
                            if (smp[i] !== 8'h00) early = 1'b1;
                        check({tag, "_early_drive"}, 8'(early), 8'd0);
                        check({tag, "_data"}, smp[e.waits + 1], e.data);
                        check({tag, "_hold"}, smp[smp.size() - 1], e.data);
                    end
                end
                check({tag, "_perr"}, 8'(protocol_err), 8'(e.err));
            end
            smp.delete();
            wlow = 0;
            zchk = 1;
        end else if (zchk != 0) begin
            zchk = 0;
            check("release_bus", data_bus, 8'h00);
            check("release_wait", 8'(WAIT_L), 8'd1);
        end
    end

    task automatic release_bus();
        M1_L = 1'b1; MREQ_L = 1'b1; IORQ_L = 1'b1;
        RD_L = 1'b1; WR_L = 1'b1; RFSH_L = 1'b1;
        tb_oe = 1'b0;
    endtask

    // Issues one bus cycle like the core would, pushing the expected response first.
    task automatic bus_cycle(input int kind, input logic [15:0] a, input logic [7:0] wd);
        exp_t e;
        int   guard = 0;
        e.kind = kind; e.addr = a; e.waits = 0; e.wr = 1'b0; e.data = 8'h00;
        case (kind)
            K_MRD, K_M1: begin
                e.waits = MEM_WAIT;
                e.data  = (int'(a) < MEM_DEPTH) ? ram[int'(a)] : 8'hFF;
            end
            K_MWR: begin
                e.waits = MEM_WAIT; e.wr = 1'b1;
                if (int'(a) >= ROM_SIZE && int'(a) < MEM_DEPTH) ram[int'(a)] = wd;
            end
            K_IORD: begin
                e.waits = IO_WAIT;
                if (port_hit(a)) e.data = io[int'(a[7:0]) - int'(IO_BASE)];
            end
            K_IOWR: begin
                e.waits = IO_WAIT; e.wr = 1'b1;
                if (port_hit(a)) io[int'(a[7:0]) - int'(IO_BASE)] = wd;
            end
            K_INTA:  e.data = INT_VECTOR;
            K_BAD:   err_m = 1'b1;
            default: ;
        endcase
        e.err = err_m;
        sb.push_back(e);

        addr_bus = a;
        case (kind)
            K_MRD:  begin MREQ_L = 1'b0; RD_L = 1'b0; end
            K_M1:   begin M1_L = 1'b0; MREQ_L = 1'b0; RD_L = 1'b0; end
            K_MWR:  begin MREQ_L = 1'b0; WR_L = 1'b0; tb_data = wd; tb_oe = 1'b1; end
            K_IORD: begin IORQ_L = 1'b0; RD_L = 1'b0; end
            K_IOWR: begin IORQ_L = 1'b0; WR_L = 1'b0; tb_data = wd; tb_oe = 1'b1; end
            K_INTA: begin M1_L = 1'b0; IORQ_L = 1'b0; end
            K_RFSH: begin MREQ_L = 1'b0; RFSH_L = 1'b0; end
            default: begin MREQ_L = 1'b0; IORQ_L = 1'b0; RD_L = 1'b0; end
        endcase
        cyc_active = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        while (!WAIT_L && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("wait_bound", 8'(guard >= 20), 8'd0);
        @(posedge clk); #1;
        release_bus();
        cyc_active = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic ld(input logic [15:0] a, input logic [7:0] d);
        ld_addr = a; ld_data = d; ld_en = 1'b1;
        if (int'(a) < MEM_DEPTH) ram[int'(a)] = d;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) io[i] = 8'h00;
        err_m = 1'b0;
    endtask

    function automatic logic [15:0] rand_mem_addr();
        case ($urandom_range(0, 3))
            0:       return 16'($urandom_range(0, ROM_SIZE - 1));
            3:       return 16'($urandom_range(MEM_DEPTH, 16'hFFFF));
            default: return 16'($urandom_range(ROM_SIZE, MEM_DEPTH - 1));
        endcase
    endfunction

    initial begin
        logic [15:0] a;
        int          k;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_wait", 8'(WAIT_L), 8'd1);
        check("reset_bus", data_bus, 8'h00);
        check("reset_perr", 8'(protocol_err), 8'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Preload all of RAM with nonzero bytes so driven data is distinguishable.
        ld_en = 1'b1;
        for (int i = 0; i < MEM_DEPTH; i++) begin
            ld_addr = 16'(i);
            ld_data = 8'($urandom_range(1, 255));
            ram[i]  = ld_data;
            @(posedge clk); #1;
        end
        ld_en = 1'b0;

        bus_cycle(K_IORD, 16'h0011, 8'h00);
        ld(16'h0000, 8'hED);
        bus_cycle(K_M1, 16'h0000, 8'h00);
        ld(16'h0500, 8'h3C);
        bus_cycle(K_MRD, 16'h0500, 8'h00);
        bus_cycle(K_MWR, 16'h0800, 8'hA5);
        bus_cycle(K_MRD, 16'h0800, 8'h00);
        bus_cycle(K_MWR, 16'h0010, 8'h55);
        bus_cycle(K_MRD, 16'h0010, 8'h00);
        bus_cycle(K_IOWR, 16'h0011, 8'h42);
        bus_cycle(K_IORD, 16'h0011, 8'h00);
        bus_cycle(K_IORD, 16'h0020, 8'h00);
        bus_cycle(K_INTA, 16'h0000, 8'h00);
        bus_cycle(K_RFSH, 16'h0123, 8'h00);
        bus_cycle(K_MRD, 16'h1000, 8'h00);
        bus_cycle(K_MWR, 16'h1000, 8'h77);
        bus_cycle(K_MRD, 16'hFFFF, 8'h00);
        bus_cycle(K_MRD, 16'h0FFF, 8'h00);
        ld(16'h0020, 8'h5A);
        bus_cycle(K_MRD, 16'h0020, 8'h00);

        // Backdoor load on the commit edge of a bus write to the same address.
        fork
            bus_cycle(K_MWR, 16'h0A00, 8'h11);
            begin
                repeat (3) @(posedge clk);
                #1;
                ld_addr = 16'h0A00; ld_data = 8'h22; ld_en = 1'b1;
                @(posedge clk); #1;
                ld_en = 1'b0;
            end
        join
        bus_cycle(K_MRD, 16'h0A00, 8'h00);
        bus_cycle(K_BAD, 16'h0300, 8'h00);

        for (int n = 0; n < 120; n++) begin
            k = (($urandom_range(0, 19)) == 0) ? K_BAD : $urandom_range(0, 6);
            if (k == K_IORD || k == K_IOWR)
                a = {8'($urandom), 8'(int'(IO_BASE) - 2 + $urandom_range(0, 7))};
            else
                a = rand_mem_addr();
            bus_cycle(k, a, 8'($urandom_range(1, 255)));
        end

        // Reset while a write sits in its wait states.
        addr_bus = 16'h0900; tb_data = 8'h99; tb_oe = 1'b1; MREQ_L = 1'b0; WR_L = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_wait", 8'(WAIT_L), 8'd0);
        rst = 1'b1;
        #1;
        check("rst_wait_release", 8'(WAIT_L), 8'd1);
        release_bus();
        #1;
        check("rst_bus_z", data_bus, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        bus_cycle(K_MRD, 16'h0900, 8'h00);

        // Reset while a read is being driven.
        addr_bus = 16'h0800; MREQ_L = 1'b0; RD_L = 1'b0;
        repeat (MEM_WAIT + 2) @(posedge clk);
        #1;
        check("pre_rst_drive", data_bus, ram[16'h0800]);
        rst = 1'b1;
        #1;
        check("rst_drive_release", data_bus, 8'h00);
        release_bus();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        bus_cycle(K_IORD, 16'h0011, 8'h00);
        bus_cycle(K_MRD, 16'h0800, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/z80_mem_responder.md
Name: z80_mem_responder

Overview:
- Bus-side responder for the z80 core's external interface: answers memory reads/writes, I/O reads/writes and interrupt-acknowledge cycles.
- Holds internal RAM with a write-protected ROM window, a small I/O register file and programmable wait-state insertion via WAIT_L.
- Sits opposite the z80 core on the shared addr_bus/data_bus; it is the synthesizable successor to the behavioural memory model used in the top-level bench.

Parameters:
- MEM_DEPTH, 4096, bytes of backing store at addresses 0..MEM_DEPTH-1.
- ROM_SIZE, 1024, addresses below this are read-only from the bus.
- MEM_WAIT, 0, extra wait cycles on memory read/write (0..7).
- IO_WAIT, 1, extra wait cycles on I/O read/write (0..7).
- IO_BASE, 8'h10, first of 4 I/O register port numbers.
- INT_VECTOR, 8'hFF, byte driven during interrupt acknowledge.

Ports:
- clk  in  1  system clock, same as z80 core.
- rst  in  1  asynchronous, active-high reset.
- addr_bus  in  16  address from core.
- data_bus  inout  8  shared data bus; driven only when responding to a read.
- M1_L  in  1  opcode-fetch / interrupt-ack marker.
- MREQ_L  in  1  memory request.
- IORQ_L  in  1  I/O request.
- RD_L  in  1  read strobe.
- WR_L  in  1  write strobe.
- RFSH_L  in  1  refresh marker.
- WAIT_L  out  1  wait request to core, active low.
- ld_en  in  1  backdoor load strobe (test/boot).
- ld_addr  in  16  backdoor address.
- ld_data  in  8  backdoor data.
- protocol_err  out  1  sticky flag, illegal strobe combination seen.

Behaviour:
- All decode is sampled at posedge clk; reset is asynchronous.
- Reset values:
  - state IDLE; WAIT_L=1; data_bus=Z; protocol_err=0; I/O regs=0.
  - Memory array is not cleared.
- Cycle classification, evaluated in IDLE:
  - MEM_RD: MREQ_L=0, RD_L=0, RFSH_L=1.
  - MEM_WR: MREQ_L=0, WR_L=0.
  - IO_RD: IORQ_L=0, RD_L=0, M1_L=1.
  - IO_WR: IORQ_L=0, WR_L=0.
  - INTA: IORQ_L=0, M1_L=0.
  - Refresh (MREQ_L=0, RFSH_L=0): ignored, nothing driven.
  - MREQ_L and IORQ_L both 0, or RD_L and WR_L both 0: cycle ignored, protocol_err set until rst.
- FSM states: IDLE -> WAITING -> ACTIVE -> HOLD -> IDLE.
  - IDLE -> WAITING: valid cycle classified and its wait count (MEM_WAIT or IO_WAIT; 0 for INTA) is nonzero. Counter loads the wait count; WAIT_L=0 from the next cycle.
  - WAITING: counter decrements each clk; at 1 -> ACTIVE, with WAIT_L=1 in the ACTIVE cycle.
  - IDLE -> ACTIVE directly when the wait count is 0.
  - ACTIVE (read/INTA): read data registered, data_bus driven from this cycle. ACTIVE (write): data_bus sampled and committed this edge.
  - HOLD: keep driving until the sampled strobe (RD_L, or IORQ_L for INTA) returns 1; then release data_bus to Z the same cycle and go to IDLE. A write goes IDLE on WR_L=1.
  - Strobe deasserting early in WAITING aborts: WAIT_L=1, no drive, no commit, IDLE.
- Read latency: 1 clk from classification with no waits; N+1 clk with N waits.
- Memory map:
  - Reads at addr >= MEM_DEPTH return 8'hFF.
  - Writes at addr < ROM_SIZE or addr >= MEM_DEPTH are dropped silently.
  - Address is 16-bit, no wrap-around aliasing.
- I/O map:
  - Port = addr_bus[7:0]; registers at IO_BASE..IO_BASE+3 are read/write.
  - Other ports: reads are not driven (bus stays Z), writes are ignored, but wait states are still inserted.
- INTA drives INT_VECTOR.
- Backdoor: ld_en writes ld_data to ld_addr in any state and ignores ROM protection. A bus write to the same address in the same cycle wins.
- rst mid-cycle releases the bus and WAIT_L immediately. A pending write is not committed.

Decomposition:
- Package z80_bus_pkg holds:
  - cycle_t enum {CYC_NONE, CYC_MEM_RD, CYC_MEM_WR, CYC_IO_RD, CYC_IO_WR, CYC_INTA}.
  - resp_state_t enum {IDLE, WAITING, ACTIVE, HOLD}.
  - Constant BUS_FLOAT = 8'hzz and constant OPEN_BUS_DATA = 8'hFF; both shared with the core.
- Sub-module z80_wait_gen: loadable 3-bit down-counter producing WAIT_L and a done pulse.

Test Plan:
- Backdoor-load 8'hED at 16'h0000; issue M1 fetch with MEM_WAIT=0 -> data_bus=8'hED one clk after classification, WAIT_L stays 1, Z after RD_L rises.
- MEM_WAIT=2; read 16'h0500 preloaded 8'h3C -> WAIT_L=0 for exactly 2 clks, then 8'h3C driven.
- Bus write 8'hA5 to 16'h0800, then read back -> 8'hA5. Write 8'h55 to 16'h0010 (ROM) -> readback unchanged.
- IO_WR 8'h42 to port 8'h11, then IO_RD port 8'h11 -> 8'h42 after 1 wait. IO_RD port 8'h20 -> bus stays Z.
- INTA (M1_L=0, IORQ_L=0) -> 8'hFF driven. MREQ_L=IORQ_L=0 together -> protocol_err=1, bus Z.
- Assert rst during WAITING of a write to 16'h0900 -> WAIT_L=1 and bus Z immediately; 16'h0900 unchanged.
